// File: rtl/iq_join.sv
// iq_join: joins independent I and Q AXI-stream lanes into one IQ pair stream.
// Each lane has a one-entry holding register. A pair advances to the
// registered output only when both lanes hold a sample. Because of this, any
// skew between the two producers is absorbed and pairing stays strictly in
// order.
// Optional build macro IQ_JOIN_SKEW_COUNT_EN enables a saturating counter of
// the cycles in which exactly one lane is holding a sample. Without the macro
// the counter is absent and skew_count reads 0.
module iq_join #(
  parameter int WIDTH      = 16,
  parameter int SKEW_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      input_i_tdata,
  input  logic                  input_i_tvalid,
  output logic                  input_i_tready,
  input  logic [WIDTH-1:0]      input_q_tdata,
  input  logic                  input_q_tvalid,
  output logic                  input_q_tready,
  output logic [WIDTH-1:0]      output_i_tdata,
  output logic [WIDTH-1:0]      output_q_tdata,
  output logic                  output_tvalid,
  input  logic                  output_tready,
  output logic [SKEW_WIDTH-1:0] skew_count
);

  logic [WIDTH-1:0] i_data_q, i_data_d;
  logic             i_valid_q, i_valid_d;
  logic [WIDTH-1:0] q_data_q, q_data_d;
  logic             q_valid_q, q_valid_d;
  logic [WIDTH-1:0] out_i_q, out_i_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic             out_valid_q, out_valid_d;
  logic             move;
  logic             i_acc;
  logic             q_acc;

  // Handshake decode: a pair moves when both lanes hold data and the output slot is free or draining
  always_comb begin
    move           = i_valid_q & q_valid_q & (~out_valid_q | output_tready);
    input_i_tready = ~i_valid_q | move;
    input_q_tready = ~q_valid_q | move;
    i_acc          = input_i_tvalid & input_i_tready;
    q_acc          = input_q_tvalid & input_q_tready;
  end

  // Next-state for holding and output registers; a lane that accepts during a move stays valid
  always_comb begin
    i_data_d    = i_data_q;
    i_valid_d   = i_valid_q;
    q_data_d    = q_data_q;
    q_valid_d   = q_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_valid_d = out_valid_q;
    if (move) begin
      out_i_d     = i_data_q;
      out_q_d     = q_data_q;
      out_valid_d = 1'b1;
      i_valid_d   = 1'b0;
      q_valid_d   = 1'b0;
    end else if (output_tready) begin
      out_valid_d = 1'b0;
    end
    if (i_acc) begin
      i_data_d  = input_i_tdata;
      i_valid_d = 1'b1;
    end
    if (q_acc) begin
      q_data_d  = input_q_tdata;
      q_valid_d = 1'b1;
    end
  end

  // State registers; reset discards every held and output sample
  always_ff @(posedge clk) begin
    if (rst) begin
      i_data_q    <= '0;
      i_valid_q   <= 1'b0;
      q_data_q    <= '0;
      q_valid_q   <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      i_data_q    <= i_data_d;
      i_valid_q   <= i_valid_d;
      q_data_q    <= q_data_d;
      q_valid_q   <= q_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign output_i_tdata = out_i_q;
  assign output_q_tdata = out_q_q;
  assign output_tvalid  = out_valid_q;

`ifdef IQ_JOIN_SKEW_COUNT_EN
  logic [SKEW_WIDTH-1:0] skew_q, skew_d;

  // Count cycles where exactly one lane is waiting, saturating at all-ones
  always_comb begin
    skew_d = skew_q;
    if ((i_valid_q ^ q_valid_q) && (skew_q != {SKEW_WIDTH{1'b1}})) begin
      skew_d = skew_q + SKEW_WIDTH'(1);
    end
  end

  // Skew counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      skew_q <= '0;
    end else begin
      skew_q <= skew_d;
    end
  end

  assign skew_count = skew_q;
`else
  assign skew_count = '0;
`endif

endmodule
